// File: rtl/block_average_downscaler.sv
// 2x2 block-average downscaler: reads a source image from a 1-cycle-latency ROM and
// writes one rounded average per 2x2 block to a half-resolution frame buffer.
module block_average_downscaler #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic [1:0]  o_dbg_state
);

  localparam int OW  = IMG_W / 2;
  localparam int OH  = IMG_H / 2;
  localparam int OXB = (OW > 1) ? $clog2(OW) : 1;
  localparam int OYB = (OH > 1) ? $clog2(OH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_phase;
  logic [OXB-1:0]   r_ox;
  logic [OYB-1:0]   r_oy;
  logic [14:0]      r_base;
  logic [14:0]      r_rom_addr;
  logic             r_d_vld;
  logic [1:0]       r_d_phase;
  logic [9:0]       r_acc;
  logic [18:0]      r_out_idx;
  logic [18:0]      r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_wr_en;
  logic             w_last_addr;
  logic             w_last_wr;
  logic             w_ox_last;
  logic [9:0]       w_sum;

  assign w_ox_last   = (r_ox == OXB'(OW - 1));
  assign w_last_addr = (r_phase == 2'd3) && w_ox_last && (r_oy == OYB'(OH - 1));
  assign w_last_wr   = r_wr_en && (r_wr_addr == 19'(OW * OH - 1));
  // Three accumulated samples plus the s3 sample on rom_q, plus rounding bias; max 1022.
  assign w_sum       = r_acc + 10'(rom_q) + 10'd2;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_addr) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_wr) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_phase    <= 2'd0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_base     <= '0;
      r_rom_addr <= '0;
      r_d_vld    <= 1'b0;
      r_d_phase  <= 2'd0;
      r_acc      <= '0;
      r_out_idx  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Whatever rom_addr shows during RUN returns its data on rom_q next cycle.
      r_d_vld   <= (r_state == S_RUN);
      r_d_phase <= r_phase;
      r_wr_en   <= 1'b0;

      if (r_state == S_IDLE && start) begin
        r_rom_addr <= '0;
        r_base     <= '0;
        r_phase    <= 2'd0;
        r_ox       <= '0;
        r_oy       <= '0;
        r_out_idx  <= '0;
      end else if (r_state == S_RUN && !w_last_addr) begin
        r_phase <= r_phase + 2'd1;
        case (r_phase)
          2'd0: r_rom_addr <= r_base + 15'd1;
          2'd1: r_rom_addr <= r_base + 15'(IMG_W);
          2'd2: r_rom_addr <= r_base + 15'(IMG_W + 1);
          default: begin
            if (w_ox_last) begin
              // Skip the odd row already consumed by this block row.
              r_ox       <= '0;
              r_oy       <= r_oy + 1'b1;
              r_base     <= r_base + 15'(IMG_W + 2);
              r_rom_addr <= r_base + 15'(IMG_W + 2);
            end else begin
              r_ox       <= r_ox + 1'b1;
              r_base     <= r_base + 15'd2;
              r_rom_addr <= r_base + 15'd2;
            end
          end
        endcase
      end

      if (r_d_vld) begin
        case (r_d_phase)
          2'd0: r_acc <= 10'(rom_q);
          2'd3: begin
            r_wr_en   <= 1'b1;
            r_wr_data <= 8'(w_sum >> 2);
            r_wr_addr <= r_out_idx;
            r_out_idx <= r_out_idx + 19'd1;
          end
          default: r_acc <= r_acc + 10'(rom_q);
        endcase
      end
    end
  end

  assign rom_addr    = r_rom_addr;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_en       = r_wr_en;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_block_average_downscaler.sv
// Scoreboard bench for block_average_downscaler: a ROM model feeds the DUT, expected
// writes are queued before each frame and a monitor pops them on every wr_en.
module tb_block_average_downscaler;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = (IMG_W / 2) * (IMG_H / 2);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [14:0] rom_addr;
  logic [7:0]  rom_q = 8'd0;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  block_average_downscaler #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  logic [7:0] rom [0:NPIX-1];
  always @(posedge clk) rom_q <= (int'(rom_addr) < NPIX) ? rom[rom_addr] : 8'hXX;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [26:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt, done_cnt, first_wr_rel, last_wr_rel, last_wr_addr, done_rel;
  int m_rel;
  int trace [0:399];
  logic busy_19202, busy_19203;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    m_rel = cyc - t0;
    if (m_rel >= 0 && m_rel < 400) trace[m_rel] = int'(rom_addr);
    if (m_rel == 19202) busy_19202 = busy;
    if (m_rel == 19203) busy_19203 = busy;
    if (wr_en) begin
      wr_cnt++;
      if (first_wr_rel < 0) first_wr_rel = m_rel;
      last_wr_rel  = m_rel;
      last_wr_addr = int'(wr_addr);
      if (exp_q.size() == 0) check("unexpected_write", int'({wr_addr, wr_data}), -1);
      else check("write_addr_data", int'({wr_addr, wr_data}), int'(exp_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_rel = m_rel;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) rom[i] = v;
  endtask

  task automatic push_const(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({19'(i), v});
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; first_wr_rel = -1; last_wr_rel = -1;
    last_wr_addr = -1; done_rel = -1; busy_19202 = 1'b0; busy_19203 = 1'b1;
    for (int i = 0; i < 400; i++) trace[i] = -1;
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("done_within_bound", int'(done_cnt > 0), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // hand-computed blocks at the start of the patterned frame: four samples and the result
  logic [7:0] pat_s [0:4][0:3];
  logic [7:0] pat_e [0:4];
  initial begin
    pat_s[0] = '{8'd0, 8'd1, 8'd2, 8'd3};       pat_e[0] = 8'h02;
    pat_s[1] = '{8'd1, 8'd1, 8'd1, 8'd2};       pat_e[1] = 8'h01;
    pat_s[2] = '{8'd255, 8'd255, 8'd255, 8'd254}; pat_e[2] = 8'hFF;
    pat_s[3] = '{8'd1, 8'd0, 8'd0, 8'd0};       pat_e[3] = 8'h00;
    pat_s[4] = '{8'd2, 8'd0, 8'd0, 8'd0};       pat_e[4] = 8'h01;
  end

  // ---------------- main sequence ----------------
  initial begin
    int expected_trace [0:7];
    expected_trace = '{0, 1, 160, 161, 2, 3, 162, 163};
    clear_stats();
    fill_rom(8'h00);

    // reset, including reset beating start in the same cycle
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset_busy", int'(busy), 0);

    // frame A: constant 0x80, stray start at cycle 100 must be ignored
    fill_rom(8'h80);
    push_const(8'h80, NOUT);
    clear_stats();
    start_frame();
    while (cyc - t0 < 100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20000);
    check("A_first_wr_cycle", first_wr_rel, 6);
    for (int i = 0; i < 8; i++) check("A_rom_addr_trace", trace[i + 1], expected_trace[i]);
    check("A_addr_ox79_s0", trace[317], 158);
    check("A_addr_ox79_s3", trace[320], 319);
    check("A_addr_row_wrap", trace[321], 320);
    check("A_write_count", wr_cnt, NOUT);
    check("A_done_count", done_cnt, 1);
    check("A_queue_empty", exp_q.size(), 0);

    // frame B: constant 0xFF, end-of-frame timing
    fill_rom(8'hFF);
    push_const(8'hFF, NOUT);
    clear_stats();
    start_frame();
    wait_done(20000);
    check("B_last_wr_cycle", last_wr_rel, 19202);
    check("B_last_wr_addr", last_wr_addr, NOUT - 1);
    check("B_done_cycle", done_rel, 19203);
    check("B_busy_at_19202", int'(busy_19202), 1);
    check("B_busy_at_19203", int'(busy_19203), 0);
    check("B_done_count", done_cnt, 1);
    check("B_write_count", wr_cnt, NOUT);

    // frame C: hand-built blocks at the top-left, rounding cases included
    fill_rom(8'h10);
    for (int p = 0; p < 5; p++) begin
      rom[2 * p]             = pat_s[p][0];
      rom[2 * p + 1]         = pat_s[p][1];
      rom[2 * p + IMG_W]     = pat_s[p][2];
      rom[2 * p + IMG_W + 1] = pat_s[p][3];
      exp_q.push_back({19'(p), pat_e[p]});
    end
    for (int i = 5; i < NOUT; i++) exp_q.push_back({19'(i), 8'h10});
    clear_stats();
    start_frame();
    wait_done(20000);
    check("C_write_count", wr_cnt, NOUT);
    check("C_queue_empty", exp_q.size(), 0);

    // frame D: reset at cycle 500 aborts; writes land at cycles 6,10,..,498
    fill_rom(8'h33);
    push_const(8'h33, 124);
    clear_stats();
    start_frame();
    while (cyc - t0 < 500) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("D_write_count", wr_cnt, 124);
    check("D_no_done", done_cnt, 0);
    check("D_queue_empty", exp_q.size(), 0);
    check("D_idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/block_average_downscaler.md
BLOCK_AVERAGE_DOWNSCALER -- requirements
Module: block_average_downscaler

Interface
REQ-001 SHALL provide parameter IMG_W, default 160, source image width in pixels (even, >=2).
REQ-002 SHALL provide parameter IMG_H, default 120, source image height in pixels (even, >=2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port start  input  1  request to process one frame; accepted only in IDLE.
REQ-006 SHALL have port rom_addr  output  15  read address to source image ROM (linear, y*IMG_W+x).
REQ-007 SHALL have port rom_q  input  8  ROM data, valid exactly one cycle after rom_addr.
REQ-008 SHALL have port wr_addr  output  19  frame-buffer write address, oy*(IMG_W/2)+ox.
REQ-009 SHALL have port wr_data  output  8  averaged pixel value.
REQ-010 SHALL have port wr_en  output  1  one-cycle write strobe qualifying wr_addr/wr_data.
REQ-011 SHALL have port busy  output  1  high while frame processing is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 at cycle 0 -> RUN; rom_addr of first sample driven (registered) in cycle 1.
REQ-015 Output pixel (ox,oy), ox in 0..IMG_W/2-1, oy in 0..IMG_H/2-1, raster order (ox fastest).
REQ-016 Per output pixel, four consecutive rom_addr cycles, order: s0=(2oy)*IMG_W+2ox, s1=s0+1, s2=s0+IMG_W, s3=s0+IMG_W+1.
REQ-017 RUN SHALL issue one new rom_addr every cycle with no bubbles; 4*(IMG_W/2)*(IMG_H/2) address cycles total.
REQ-018 Sample issued in cycle t SHALL be accumulated from rom_q in cycle t+1; accumulator 10 bits, cleared on s0 data.
REQ-019 wr_data SHALL be (s0+s1+s2+s3+2)>>2 (round-half-up), truncated to 8 bits; max result 255, no overflow.
REQ-020 wr_en/wr_addr/wr_data SHALL be valid in cycle t+2 where t is the s3 address cycle; wr_en high for exactly that cycle.
REQ-021 After last address issued, RUN -> DRAIN; DRAIN holds until final wr_en asserted, then -> DONE.
REQ-022 DONE SHALL assert done for one cycle, then -> IDLE.
REQ-023 busy SHALL be high from cycle 1 through the final wr_en cycle; low in IDLE and DONE.
REQ-024 start while not IDLE (RUN/DRAIN/DONE) SHALL be ignored, no restart or re-queue.
REQ-025 start held high continuously SHALL start a new frame on each IDLE visit (level-sensitive acceptance).
REQ-026 rom_addr SHALL hold its last value when not in RUN; wr_addr/wr_data hold last value when wr_en=0.
REQ-027 ox/oy counters SHALL wrap ox to 0 and increment oy at ox=IMG_W/2-1; no address beyond IMG_W*IMG_H-1 issued.

Reset
REQ-028 reset=0 on a rising clk SHALL force IDLE, accumulator/counters to 0, rom_addr=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, done=0.
REQ-029 reset mid-frame SHALL abort immediately: no further wr_en or done pulse for the aborted frame.
REQ-030 reset SHALL take priority over start in the same cycle.

Verification
REQ-031 Constant ROM 0x80, start at cycle 0 -> first wr_en cycle 6 with wr_addr=0, wr_data=0x80; 4800 writes, all 0x80.
REQ-032 ROM block (0,0)=0,(1,0)=1,(0,1)=2,(1,1)=3 -> wr_addr 0 wr_data 0x02; block 1,1,1,2 -> 0x01 (5+2=7>>2).
REQ-033 Constant ROM 0xFF -> every wr_data 0xFF; last wr_en cycle 19202 wr_addr 4799; done only at cycle 19203; busy low at 19203.
REQ-034 start pulsed at cycle 100 while busy -> write count stays 4800, done pulses exactly once.
REQ-035 reset=0 at cycle 500 during RUN -> next cycle all outputs at reset values, no wr_en/done until a new start.
REQ-036 rom_addr trace check: cycles 1..4 = 0,1,160,161; cycles 5..8 = 2,3,162,163; address after ox=79 row 0 is 320.
